// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register with writeback bypass, load-use stall/bubble and branch flush.
// Latency : one cycle ID->EX; stallOut is combinational (same cycle as the hazard).
// Backpressure: stallOut holds PC and IF/ID for exactly one cycle while a bubble enters EX.
//
// Ports:
//   clock/reset          rising-edge clock, asynchronous active-high reset
//   id*                  decoded instruction fields from IF/ID
//   bankData1/2          register bank read ports for idRs1/idRs2
//   wbRd/wbRegWrite/wbData  writeback port (wbRegWrite active-low), bypassed around the bank
//   flush                kill the instruction entering EX
//   cntClear             synchronous clear of bubbleCount
//   stallOut             hold PC and IF/ID this cycle
//   ex*                  registered ID/EX fields and operands
//   bubbleCount          saturating count of load-use bubbles
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              idValid,
   input  logic [XLEN-1:0]   idPc,
   input  logic [4:0]        idRs1,
   input  logic [4:0]        idRs2,
   input  logic [4:0]        idRd,
   input  logic              idUsesRs1,
   input  logic              idUsesRs2,
   input  logic [XLEN-1:0]   idImm,
   input  logic [CTRL_W-1:0] idCtrl,
   input  logic              idMemRead,
   input  logic [XLEN-1:0]   bankData1,
   input  logic [XLEN-1:0]   bankData2,
   input  logic [4:0]        wbRd,
   input  logic              wbRegWrite,
   input  logic [XLEN-1:0]   wbData,
   input  logic              flush,
   input  logic              cntClear,
   output logic              stallOut,
   output logic              exValid,
   output logic [XLEN-1:0]   exPc,
   output logic [4:0]        exRs1,
   output logic [4:0]        exRs2,
   output logic [4:0]        exRd,
   output logic [XLEN-1:0]   exImm,
   output logic [CTRL_W-1:0] exCtrl,
   output logic              exMemRead,
   output logic [XLEN-1:0]   exRs1Data,
   output logic [XLEN-1:0]   exRs2Data,
   output logic [CNT_W-1:0]  bubbleCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              ex_valid_q,    ex_valid_d;
   logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
   logic [4:0]        ex_rs1_q,      ex_rs1_d;
   logic [4:0]        ex_rs2_q,      ex_rs2_d;
   logic [4:0]        ex_rd_q,       ex_rd_d;
   logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
   logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
   logic              ex_mem_read_q, ex_mem_read_d;
   logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
   logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
   logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;

   logic [XLEN-1:0]   op1, op2;
   logic              load_use;

   // The bank writes on the same edge we sample, so a matching writeback
   // must be forwarded here; x0 always reads as zero.
   always_comb begin
      op1 = bankData1;
      if (idRs1 == 5'd0)
         op1 = '0;
      else if (!wbRegWrite && (wbRd == idRs1))
         op1 = wbData;

      op2 = bankData2;
      if (idRs2 == 5'd0)
         op2 = '0;
      else if (!wbRegWrite && (wbRd == idRs2))
         op2 = wbData;
   end

   assign load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) & idValid &
                     ((idUsesRs1 & (idRs1 == ex_rd_q)) | (idUsesRs2 & (idRs2 == ex_rd_q)));

   // A taken branch makes the dependent instruction wrong-path, so no stall.
   assign stallOut = load_use & ~flush;

   always_comb begin
      ex_valid_d    = idValid;
      ex_pc_d       = idPc;
      ex_rs1_d      = idRs1;
      ex_rs2_d      = idRs2;
      ex_rd_d       = idRd;
      ex_imm_d      = idImm;
      ex_ctrl_d     = idValid ? idCtrl : '0;
      ex_mem_read_d = idValid & idMemRead;
      ex_rs1_data_d = op1;
      ex_rs2_data_d = op2;

      if (flush || load_use) begin
         ex_valid_d    = 1'b0;
         ex_pc_d       = '0;
         ex_rs1_d      = '0;
         ex_rs2_d      = '0;
         ex_rd_d       = '0;
         ex_imm_d      = '0;
         ex_ctrl_d     = '0;
         ex_mem_read_d = 1'b0;
         ex_rs1_data_d = '0;
         ex_rs2_data_d = '0;
      end

      // Only load-use bubbles are counted; clear beats increment.
      bubble_cnt_d = bubble_cnt_q;
      if (cntClear)
         bubble_cnt_d = '0;
      else if (stallOut && (bubble_cnt_q != CNT_MAX))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rd_q       <= '0;
         ex_imm_q      <= '0;
         ex_ctrl_q     <= '0;
         ex_mem_read_q <= 1'b0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         bubble_cnt_q  <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         ex_imm_q      <= ex_imm_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_mem_read_q <= ex_mem_read_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end

   assign exValid     = ex_valid_q;
   assign exPc        = ex_pc_q;
   assign exRs1       = ex_rs1_q;
   assign exRs2       = ex_rs2_q;
   assign exRd        = ex_rd_q;
   assign exImm       = ex_imm_q;
   assign exCtrl      = ex_ctrl_q;
   assign exMemRead   = ex_mem_read_q;
   assign exRs1Data   = ex_rs1_data_q;
   assign exRs2Data   = ex_rs2_data_q;
   assign bubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose : directed self-checking bench for id_ex_stage (default widths plus a CNT_W=4 copy).
// Latency : registered outputs sampled 1 time unit after the rising edge; stallOut sampled combinationally.
// Backpressure: not applicable; all stimulus is fixed-length.
module tb_id_ex_stage;
   localparam int XLEN   = 32;
   localparam int CTRL_W = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              idValid;
   logic [XLEN-1:0]   idPc;
   logic [4:0]        idRs1, idRs2, idRd;
   logic              idUsesRs1, idUsesRs2;
   logic [XLEN-1:0]   idImm;
   logic [CTRL_W-1:0] idCtrl;
   logic              idMemRead;
   logic [XLEN-1:0]   bankData1, bankData2;
   logic [4:0]        wbRd;
   logic              wbRegWrite;
   logic [XLEN-1:0]   wbData;
   logic              flush, cntClear;

   logic              stallOut, exValid, exMemRead;
   logic [XLEN-1:0]   exPc, exImm, exRs1Data, exRs2Data;
   logic [4:0]        exRs1, exRs2, exRd;
   logic [CTRL_W-1:0] exCtrl;
   logic [15:0]       bubbleCount;

   logic              s4_stallOut, s4_exValid, s4_exMemRead;
   logic [XLEN-1:0]   s4_exPc, s4_exImm, s4_exRs1Data, s4_exRs2Data;
   logic [4:0]        s4_exRs1, s4_exRs2, s4_exRd;
   logic [CTRL_W-1:0] s4_exCtrl;
   logic [3:0]        s4_bubbleCount;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   id_ex_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .idValid(idValid), .idPc(idPc),
      .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idUsesRs1(idUsesRs1),
      .idUsesRs2(idUsesRs2), .idImm(idImm), .idCtrl(idCtrl), .idMemRead(idMemRead),
      .bankData1(bankData1), .bankData2(bankData2), .wbRd(wbRd),
      .wbRegWrite(wbRegWrite), .wbData(wbData), .flush(flush), .cntClear(cntClear),
      .stallOut(stallOut), .exValid(exValid), .exPc(exPc), .exRs1(exRs1),
      .exRs2(exRs2), .exRd(exRd), .exImm(exImm), .exCtrl(exCtrl),
      .exMemRead(exMemRead), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
      .bubbleCount(bubbleCount)
   );

   id_ex_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(4)) dut4 (
      .clock(clock), .reset(reset), .idValid(idValid), .idPc(idPc),
      .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idUsesRs1(idUsesRs1),
      .idUsesRs2(idUsesRs2), .idImm(idImm), .idCtrl(idCtrl), .idMemRead(idMemRead),
      .bankData1(bankData1), .bankData2(bankData2), .wbRd(wbRd),
      .wbRegWrite(wbRegWrite), .wbData(wbData), .flush(flush), .cntClear(cntClear),
      .stallOut(s4_stallOut), .exValid(s4_exValid), .exPc(s4_exPc), .exRs1(s4_exRs1),
      .exRs2(s4_exRs2), .exRd(s4_exRd), .exImm(s4_exImm), .exCtrl(s4_exCtrl),
      .exMemRead(s4_exMemRead), .exRs1Data(s4_exRs1Data), .exRs2Data(s4_exRs2Data),
      .bubbleCount(s4_bubbleCount)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      idValid = 1'b0; idPc = '0; idRs1 = '0; idRs2 = '0; idRd = '0;
      idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idImm = '0; idCtrl = '0; idMemRead = 1'b0;
      bankData1 = '0; bankData2 = '0; wbRd = '0; wbRegWrite = 1'b1; wbData = '0;
      flush = 1'b0; cntClear = 1'b0;
   endtask

   task automatic drive_load(input logic [4:0] rd);
      idle();
      idValid = 1'b1; idMemRead = 1'b1; idRd = rd; idRs1 = 5'd1; idUsesRs1 = 1'b1;
      idCtrl = 8'h5A; idPc = 32'h40;
   endtask

   task automatic drive_dep(input logic [4:0] rs2);
      idle();
      idValid = 1'b1; idRs2 = rs2; idUsesRs2 = 1'b1; idRd = 5'd9;
      idCtrl = 8'h33; idPc = 32'h44;
   endtask

   // Load into EX, then the dependent instruction sits in ID across one edge (bubble).
   task automatic stall_pair();
      drive_load(5'd7);
      tick();
      drive_dep(5'd7);
      tick();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      #3;
      checks++;
      if (exValid !== 1'b0 || exPc !== '0 || exRs1Data !== '0 || exCtrl !== '0 ||
          bubbleCount !== 16'd0 || stallOut !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: exValid=%0b exPc=%h exRs1Data=%h cnt=%0d stall=%0b, want all 0",
                  exValid, exPc, exRs1Data, bubbleCount, stallOut);
      end
      @(negedge clock);
      reset = 1'b0;
      tick();
   endtask

   task automatic test_capture();
      idle();
      idValid = 1'b1; idRs1 = 5'd3; idRs2 = 5'd4; idRd = 5'd10; idPc = 32'h100;
      idImm = 32'hFFFF_FFFC; idCtrl = 8'h81; bankData1 = 32'h11; bankData2 = 32'h22;
      #1;
      checks++;
      if (stallOut !== 1'b0) begin
         failures++;
         $display("FAIL capture_nostall: stallOut=%0b want 0", stallOut);
      end
      tick();
      checks++;
      if (exRs1Data !== 32'h11 || exRs2Data !== 32'h22 || exValid !== 1'b1) begin
         failures++;
         $display("FAIL capture_data: rs1=%h rs2=%h valid=%0b want 11 22 1", exRs1Data, exRs2Data, exValid);
      end
      checks++;
      if (exPc !== 32'h100 || exImm !== 32'hFFFF_FFFC || exCtrl !== 8'h81 || exRd !== 5'd10 ||
          exRs1 !== 5'd3 || exRs2 !== 5'd4) begin
         failures++;
         $display("FAIL capture_fields: pc=%h imm=%h ctrl=%h rd=%0d rs1=%0d rs2=%0d want 100 fffffffc 81 10 3 4",
                  exPc, exImm, exCtrl, exRd, exRs1, exRs2);
      end
      // Invalid slot: control and memRead are squashed, other fields pass through.
      idValid = 1'b0; idMemRead = 1'b1; idCtrl = 8'hFF; idPc = 32'h200;
      tick();
      checks++;
      if (exValid !== 1'b0 || exCtrl !== 8'h00 || exMemRead !== 1'b0 || exPc !== 32'h200) begin
         failures++;
         $display("FAIL capture_invalid: valid=%0b ctrl=%h memRd=%0b pc=%h want 0 00 0 200",
                  exValid, exCtrl, exMemRead, exPc);
      end
   endtask

   task automatic test_bypass();
      idle();
      idValid = 1'b1; idRs1 = 5'd5; idRs2 = 5'd5; bankData1 = 32'hAAAA; bankData2 = 32'hBBBB;
      wbRegWrite = 1'b0; wbRd = 5'd5; wbData = 32'h1234;
      tick();
      checks++;
      if (exRs1Data !== 32'h1234 || exRs2Data !== 32'h1234) begin
         failures++;
         $display("FAIL bypass_hit: rs1=%h rs2=%h want 1234 1234", exRs1Data, exRs2Data);
      end
      idRs1 = 5'd0; wbRd = 5'd0; idRs2 = 5'd6;
      tick();
      checks++;
      if (exRs1Data !== 32'h0 || exRs2Data !== 32'hBBBB) begin
         failures++;
         $display("FAIL bypass_x0: rs1=%h rs2=%h want 0 bbbb", exRs1Data, exRs2Data);
      end
      idRs1 = 5'd5; wbRd = 5'd5; wbRegWrite = 1'b1;
      tick();
      checks++;
      if (exRs1Data !== 32'hAAAA) begin
         failures++;
         $display("FAIL bypass_disabled: rs1=%h want aaaa", exRs1Data);
      end
   endtask

   task automatic test_load_use();
      drive_load(5'd7);
      tick();
      checks++;
      if (exMemRead !== 1'b1 || exRd !== 5'd7) begin
         failures++;
         $display("FAIL lu_load_in_ex: memRd=%0b rd=%0d want 1 7", exMemRead, exRd);
      end
      drive_dep(5'd7);
      #1;
      checks++;
      if (stallOut !== 1'b1) begin
         failures++;
         $display("FAIL lu_stall: stallOut=%0b want 1", stallOut);
      end
      tick();
      checks++;
      if (exValid !== 1'b0 || exRd !== 5'd0 || exCtrl !== 8'h00 || exPc !== '0 ||
          bubbleCount !== 16'd1 || stallOut !== 1'b0) begin
         failures++;
         $display("FAIL lu_bubble: valid=%0b rd=%0d ctrl=%h pc=%h cnt=%0d stall=%0b want 0 0 00 0 1 0",
                  exValid, exRd, exCtrl, exPc, bubbleCount, stallOut);
      end
      tick();
      checks++;
      if (exValid !== 1'b1 || exRd !== 5'd9 || exCtrl !== 8'h33 || exRs2 !== 5'd7) begin
         failures++;
         $display("FAIL lu_release: valid=%0b rd=%0d ctrl=%h rs2=%0d want 1 9 33 7",
                  exValid, exRd, exCtrl, exRs2);
      end
      // Dependency through rs1 also stalls.
      drive_load(5'd7);
      tick();
      drive_dep(5'd0);
      idRs1 = 5'd7; idUsesRs1 = 1'b1; idUsesRs2 = 1'b0;
      #1;
      checks++;
      if (stallOut !== 1'b1) begin
         failures++;
         $display("FAIL lu_rs1_stall: stallOut=%0b want 1", stallOut);
      end
      tick();
      checks++;
      if (bubbleCount !== 16'd2) begin
         failures++;
         $display("FAIL lu_rs1_count: cnt=%0d want 2", bubbleCount);
      end
   endtask

   task automatic test_flush_and_x0();
      drive_load(5'd7);
      tick();
      drive_dep(5'd7);
      flush = 1'b1;
      #1;
      checks++;
      if (stallOut !== 1'b0) begin
         failures++;
         $display("FAIL flush_stall: stallOut=%0b want 0", stallOut);
      end
      tick();
      checks++;
      if (exValid !== 1'b0 || exRd !== 5'd0 || bubbleCount !== 16'd2) begin
         failures++;
         $display("FAIL flush_bubble: valid=%0b rd=%0d cnt=%0d want 0 0 2", exValid, exRd, bubbleCount);
      end
      drive_load(5'd0);
      tick();
      drive_dep(5'd0);
      #1;
      checks++;
      if (stallOut !== 1'b0) begin
         failures++;
         $display("FAIL x0_stall: stallOut=%0b want 0", stallOut);
      end
      tick();
      checks++;
      if (exValid !== 1'b1 || bubbleCount !== 16'd2) begin
         failures++;
         $display("FAIL x0_capture: valid=%0b cnt=%0d want 1 2", exValid, bubbleCount);
      end
   endtask

   task automatic test_saturation();
      idle();
      cntClear = 1'b1;
      tick();
      cntClear = 1'b0;
      checks++;
      if (bubbleCount !== 16'd0 || s4_bubbleCount !== 4'd0) begin
         failures++;
         $display("FAIL sat_clear: cnt=%0d cnt4=%0d want 0 0", bubbleCount, s4_bubbleCount);
      end
      for (int i = 0; i < 15; i++) stall_pair();
      checks++;
      if (s4_bubbleCount !== 4'd15) begin
         failures++;
         $display("FAIL sat_reach: cnt4=%0d want 15", s4_bubbleCount);
      end
      stall_pair();
      checks++;
      if (s4_bubbleCount !== 4'd15 || bubbleCount !== 16'd16) begin
         failures++;
         $display("FAIL sat_hold: cnt4=%0d cnt=%0d want 15 16", s4_bubbleCount, bubbleCount);
      end
      drive_load(5'd7);
      tick();
      drive_dep(5'd7);
      cntClear = 1'b1;
      #1;
      checks++;
      if (stallOut !== 1'b1) begin
         failures++;
         $display("FAIL sat_clr_stall: stallOut=%0b want 1", stallOut);
      end
      tick();
      cntClear = 1'b0;
      checks++;
      if (s4_bubbleCount !== 4'd0 || bubbleCount !== 16'd0 || exValid !== 1'b0) begin
         failures++;
         $display("FAIL sat_clr_priority: cnt4=%0d cnt=%0d valid=%0b want 0 0 0",
                  s4_bubbleCount, bubbleCount, exValid);
      end
   endtask

   task automatic test_reset_mid_stall();
      for (int i = 0; i < 5; i++) stall_pair();
      drive_load(5'd7);
      tick();
      drive_dep(5'd7);
      #1;
      checks++;
      if (exValid !== 1'b1 || stallOut !== 1'b1 || bubbleCount !== 16'd5) begin
         failures++;
         $display("FAIL rst_pre: valid=%0b stall=%0b cnt=%0d want 1 1 5", exValid, stallOut, bubbleCount);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (exValid !== 1'b0 || exPc !== '0 || exRd !== 5'd0 || exMemRead !== 1'b0 ||
          exCtrl !== 8'h00 || exImm !== '0 || bubbleCount !== 16'd0 || stallOut !== 1'b0) begin
         failures++;
         $display("FAIL rst_async: valid=%0b pc=%h rd=%0d memRd=%0b ctrl=%h cnt=%0d stall=%0b want all 0",
                  exValid, exPc, exRd, exMemRead, exCtrl, bubbleCount, stallOut);
      end
      #1;
      reset = 1'b0;
      tick();
      checks++;
      if (exValid !== 1'b1 || exRd !== 5'd9 || exCtrl !== 8'h33 || bubbleCount !== 16'd0) begin
         failures++;
         $display("FAIL rst_release: valid=%0b rd=%0d ctrl=%h cnt=%0d want 1 9 33 0",
                  exValid, exRd, exCtrl, bubbleCount);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_bypass();
      test_load_use();
      test_flush_and_x0();
      test_saturation();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RISC-V merge-sort pipeline, directly downstream of the register bank.
- Captures the two register-bank read ports plus decoded instruction fields into the ID/EX register.
- Bypasses same-cycle writeback data around the register bank, detects load-use hazards (stalls IF/ID and inserts a bubble), and applies branch flushes.
- Keeps a saturating count of load-use bubbles for performance measurement.

Parameters:
- XLEN, 32, data/PC/immediate width
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle carried through the stage
- CNT_W, 16, width of the bubble counter

Ports:
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- idValid  in  1  IF/ID holds a real instruction
- idPc  in  XLEN  instruction PC
- idRs1  in  5  source register 1 index (also drives bank rs1)
- idRs2  in  5  source register 2 index (also drives bank rs2)
- idRd  in  5  destination index
- idUsesRs1  in  1  instruction reads rs1
- idUsesRs2  in  1  instruction reads rs2
- idImm  in  XLEN  sign-extended immediate
- idCtrl  in  CTRL_W  control bundle
- idMemRead  in  1  instruction is a load
- bankData1  in  XLEN  register bank outReg1
- bankData2  in  XLEN  register bank outReg2
- wbRd  in  5  writeback destination (same value driven to bank rd)
- wbRegWrite  in  1  writeback enable, active-low (0 = write), identical to bank regWrite
- wbData  in  XLEN  writeback data (same as bank writeData)
- flush  in  1  branch/jump resolved taken in EX; kill the instruction entering EX
- cntClear  in  1  synchronous clear of bubbleCount
- stallOut  out  1  hold PC and IF/ID this cycle
- exValid, exPc, exRs1, exRs2, exRd, exImm, exCtrl, exMemRead  out  as inputs  registered ID/EX fields
- exRs1Data  out  XLEN  registered operand 1
- exRs2Data  out  XLEN  registered operand 2
- bubbleCount  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset: all ex* outputs 0, exValid 0, bubbleCount 0. stallOut is therefore 0, because exValid = 0.
- Operand bypass (combinational):
  - op1 = 0 if idRs1 == 0.
  - Else op1 = wbData if wbRegWrite == 0 and wbRd == idRs1.
  - Else op1 = bankData1.
  - op2 is selected the same way from idRs2 and bankData2.
  - Required because the bank writes on the same edge the stage samples.
- Load-use detect (combinational): loadUse = exValid & exMemRead & (exRd != 0) & idValid & ((idUsesRs1 & idRs1 == exRd) | (idUsesRs2 & idRs2 == exRd)).
- stallOut = loadUse & ~flush. stallOut has zero latency: it is asserted in the same cycle loadUse is true.
- Rising-edge update, in priority order:
  1. flush = 1: bubble.
  2. loadUse = 1: bubble, and bubbleCount increments.
  3. Otherwise capture: exValid <= idValid; fields <= id*; data <= op1/op2.
- Bubble definition: exValid, exCtrl, exMemRead, exRd, exRs1, exRs2, exRs1Data, exRs2Data, exImm and exPc are all set to 0.
- Capture with idValid = 0: exCtrl and exMemRead are forced to 0. The other fields are captured unchanged.
- Counter rules:
  - bubbleCount saturates at all-ones and does not wrap.
  - cntClear has priority over an increment in the same cycle; the result is 0.
  - Flush bubbles are not counted.
- Flush and loadUse in the same cycle: flush wins, stallOut = 0, count unchanged. The load-dependent instruction in IF/ID is on the wrong path.
- A stall lasts exactly one cycle. On the next cycle the load has left ID/EX (it is now a bubble), so the held instruction captures.
- Asynchronous reset asserted mid-stall: outputs clear immediately. The first edge after release captures normally.

Test Plan:
- Reset asserted mid-cycle with exValid = 1 and bubbleCount = 5 -> all ex* outputs, bubbleCount and stallOut read 0 before the next edge.
- idValid = 1, idRs1 = 3, idRs2 = 4, bank = 0x11/0x22, wbRegWrite = 1 -> next edge exRs1Data = 0x11, exRs2Data = 0x22, exValid = 1, no stall.
- Bypass: idRs1 = 5, bank = 0xAAAA, wbRegWrite = 0, wbRd = 5, wbData = 0x1234 -> exRs1Data = 0x1234. Repeat with idRs1 = 0 and wbRd = 0 -> exRs1Data = 0.
- Load-use: ID/EX holds a load with exRd = 7; IF/ID holds idRs2 = 7, idUsesRs2 = 1 -> stallOut = 1 for one cycle, a bubble is inserted (exValid = 0), bubbleCount = 1. The next edge captures the held instruction.
- Same load-use hazard with flush = 1 -> stallOut = 0, bubble inserted, bubbleCount unchanged. Dependency on x0 (exRd = 0) -> no stall.
- CNT_W = 4: force 16 load-use stalls -> bubbleCount holds at 15. Assert cntClear together with a stall -> bubbleCount = 0.
